// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file with issue scoreboard.
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Register file access bundle: read ports, write ports, issue port and scoreboard view.
interface regfile_mp_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned NUM_WR = 1
);
    localparam int unsigned AW = $clog2(NREGS);

    logic                     stall;
    logic [NUM_RD*AW-1:0]     rs_idx;
    logic [NUM_RD*XLEN-1:0]   rs_data;
    logic [NUM_RD-1:0]        rs_busy;
    logic [NUM_WR-1:0]        we;
    logic [NUM_WR*AW-1:0]     rd_idx;
    logic [NUM_WR*XLEN-1:0]   wb_data;
    logic                     iss_valid;
    logic [AW-1:0]            iss_rd;
    logic [NREGS-1:0]         busy_vec;

    modport master (
        output stall, rs_idx, we, rd_idx, wb_data, iss_valid, iss_rd,
        input  rs_data, rs_busy, busy_vec
    );

    modport slave (
        input  stall, rs_idx, we, rd_idx, wb_data, iss_valid, iss_rd,
        output rs_data, rs_busy, busy_vec
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on writeback.
module regfile_scoreboard import regfile_pkg::*; #(
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned NUM_WR = 1,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_WR-1:0]    wr_acc,
    input  logic [NUM_WR*AW-1:0] wr_idx,
    input  logic                 iss_acc,
    input  logic [AW-1:0]        iss_rd,
    output logic [NREGS-1:0]     busy
);

    logic [NREGS-1:0] busy_nxt;

    // Writebacks clear first so a same-cycle issue to the same register leaves it busy.
    always_comb begin
        busy_nxt = busy;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_acc[j]) begin
                busy_nxt[wr_idx[j*AW +: AW]] = 1'b0;
            end
        end
        if (iss_acc) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with issue scoreboard; x0 is hardwired to zero.
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_mp import regfile_pkg::*; #(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned NUM_WR = 1
) (
    input logic         clk,
    input logic         reset,
    regfile_mp_if.slave bus
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0]   regs [NREGS];
    logic [NUM_WR-1:0] wr_acc;
    logic              iss_acc;
    logic [NREGS-1:0]  busy;

    // Write/issue acceptance: blocked by stall and reset, never targets x0.
    always_comb begin
        wr_acc = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            wr_acc[j] = bus.we[j] && !bus.stall && !reset && (bus.rd_idx[j*AW +: AW] != '0);
        end
        iss_acc = bus.iss_valid && !bus.stall && !reset && (bus.iss_rd != '0);
    end

    // Later ports are assigned last, so the highest write port wins on a collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_acc[j]) begin
                    regs[bus.rd_idx[j*AW +: AW]] <= bus.wb_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .wr_acc  (wr_acc),
        .wr_idx  (bus.rd_idx),
        .iss_acc (iss_acc),
        .iss_rd  (bus.iss_rd),
        .busy    (busy)
    );

    always_comb begin : rd_mux
        logic [AW-1:0] sel;
        sel         = '0;
        bus.rs_data = '0;
        bus.rs_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            sel = bus.rs_idx[k*AW +: AW];
            if (sel != '0) begin
                bus.rs_data[k*XLEN +: XLEN] = regs[sel];
                bus.rs_busy[k]              = busy[sel];
            end
`ifdef REGFILE_BYPASS_EN
            // Forward the winning same-cycle write; a coincident issue keeps it busy.
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_acc[j] && (bus.rd_idx[j*AW +: AW] == sel)) begin
                    bus.rs_data[k*XLEN +: XLEN] = bus.wb_data[j*XLEN +: XLEN];
                    bus.rs_busy[k]              = iss_acc && (bus.iss_rd == sel);
                end
            end
`endif
        end
    end

    assign bus.busy_vec = busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: vector table, reset sweep and bypass sequences.
module tb_regfile_mp;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2)) bus ();

    regfile_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        string       nm;
        logic        rst;
        logic        stall;
        logic [1:0]  we;
        reg_idx_t    rd0;
        logic [31:0] wb0;
        reg_idx_t    rd1;
        logic [31:0] wb1;
        logic        iv;
        reg_idx_t    ird;
        reg_idx_t    rs0;
        reg_idx_t    rs1;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
        logic [1:0]  e_b;
        logic [31:0] e_bv;
    } vec_t;

    typedef struct {
        string       nm;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  b;
        logic [31:0] bv;
    } exp_t;

    vec_t vecs[12];
    exp_t expq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic push(input string nm, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [1:0] b, input logic [31:0] bv);
        exp_t e;
        e.nm = nm; e.d0 = d0; e.d1 = d1; e.b = b; e.bv = bv;
        expq.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty got=0 entries want>=1");
            return;
        end
        e = expq.pop_front();
        chk({e.nm, "/d0"}, bus.rs_data[31:0], e.d0);
        chk({e.nm, "/d1"}, bus.rs_data[63:32], e.d1);
        chk({e.nm, "/busy"}, 32'(bus.rs_busy), 32'(e.b));
        chk({e.nm, "/bvec"}, bus.busy_vec, e.bv);
    endtask

    task automatic drive(input vec_t v);
        reset         = v.rst;
        bus.stall     = v.stall;
        bus.we        = v.we;
        bus.rd_idx    = {v.rd1, v.rd0};
        bus.wb_data   = {v.wb1, v.wb0};
        bus.iss_valid = v.iv;
        bus.iss_rd    = v.ird;
        bus.rs_idx    = {v.rs1, v.rs0};
    endtask

    task automatic set_idle();
        reset         = 1'b0;
        bus.stall     = 1'b0;
        bus.we        = '0;
        bus.rd_idx    = '0;
        bus.wb_data   = '0;
        bus.iss_valid = 1'b0;
        bus.iss_rd    = '0;
        bus.rs_idx    = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          nm           rst  stl  we     rd0    wb0            rd1    wb1            iv   ird    rs0    rs1    e_d0           e_d1           e_b    e_bv
        vecs[0]  = '{"wr_x5",    1'b0,1'b0,2'b01, 5'd5,  32'hDEADBEEF,  5'd0,  32'h0,         1'b0,5'd0,  5'd5,  5'd5,  32'hDEADBEEF,  32'hDEADBEEF,  2'b00, 32'h0};
        vecs[1]  = '{"wr_x0",    1'b0,1'b0,2'b01, 5'd0,  32'h1234,      5'd0,  32'h0,         1'b0,5'd0,  5'd0,  5'd5,  32'h0,         32'hDEADBEEF,  2'b00, 32'h0};
        vecs[2]  = '{"dual_x7",  1'b0,1'b0,2'b11, 5'd7,  32'h11,        5'd7,  32'h22,        1'b0,5'd0,  5'd7,  5'd5,  32'h22,        32'hDEADBEEF,  2'b00, 32'h0};
        vecs[3]  = '{"iss_x3",   1'b0,1'b0,2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         1'b1,5'd3,  5'd3,  5'd7,  32'h0,         32'h22,        2'b01, 32'h8};
        vecs[4]  = '{"wb_x3",    1'b0,1'b0,2'b10, 5'd0,  32'h0,         5'd3,  32'h33,        1'b0,5'd0,  5'd3,  5'd3,  32'h33,        32'h33,        2'b00, 32'h0};
        vecs[5]  = '{"iss_wb_x3",1'b0,1'b0,2'b01, 5'd3,  32'h44,        5'd0,  32'h0,         1'b1,5'd3,  5'd3,  5'd0,  32'h44,        32'h0,         2'b01, 32'h8};
        vecs[6]  = '{"wr_x4",    1'b0,1'b0,2'b01, 5'd4,  32'h0A,        5'd0,  32'h0,         1'b0,5'd0,  5'd4,  5'd3,  32'h0A,        32'h44,        2'b10, 32'h8};
        vecs[7]  = '{"stall_x4", 1'b0,1'b1,2'b01, 5'd4,  32'hAA,        5'd0,  32'h0,         1'b1,5'd4,  5'd4,  5'd3,  32'h0A,        32'h44,        2'b10, 32'h8};
        vecs[8]  = '{"iss_x4",   1'b0,1'b0,2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         1'b1,5'd4,  5'd4,  5'd3,  32'h0A,        32'h44,        2'b11, 32'h18};
        vecs[9]  = '{"iss_x0",   1'b0,1'b0,2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         1'b1,5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         2'b00, 32'h18};
        vecs[10] = '{"wr_x31_x4",1'b0,1'b0,2'b11, 5'd4,  32'h40,        5'd31, 32'hFFFFFFFF,  1'b0,5'd0,  5'd31, 5'd4,  32'hFFFFFFFF,  32'h40,        2'b00, 32'h8};
        vecs[11] = '{"rst_stall",1'b1,1'b1,2'b11, 5'd5,  32'h99,        5'd6,  32'h66,        1'b1,5'd8,  5'd5,  5'd3,  32'h0,         32'h0,         2'b00, 32'h0};

        set_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        set_idle();

        // Every index reads zero and idle after reset.
        for (int i = 0; i < 32; i++) begin
            bus.rs_idx = {5'(i), 5'(31 - i)};
            #1;
            push("rst_sweep", 32'h0, 32'h0, 2'b00, 32'h0);
            check_out();
        end

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            push(vecs[i].nm, vecs[i].e_d0, vecs[i].e_d1, vecs[i].e_b, vecs[i].e_bv);
            @(posedge clk);
            #1;
            check_out();
        end

        // Bypass sequence on x9: seed value, mark busy, then same-cycle write/read.
        @(negedge clk);
        set_idle();
        bus.we = 2'b01; bus.rd_idx = {5'd0, 5'd9}; bus.wb_data = {32'h0, 32'h33};
        bus.rs_idx = {5'd0, 5'd9};
        push("seed_x9", 32'h33, 32'h0, 2'b00, 32'h0);
        @(posedge clk); #1; check_out();

        @(negedge clk);
        set_idle();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
        bus.rs_idx = {5'd0, 5'd9};
        push("busy_x9", 32'h33, 32'h0, 2'b01, 32'h200);
        @(posedge clk); #1; check_out();

        @(negedge clk);
        set_idle();
        bus.we = 2'b10; bus.rd_idx = {5'd9, 5'd0}; bus.wb_data = {32'h55, 32'h0};
        bus.rs_idx = {5'd9, 5'd9};
        #1;
`ifdef REGFILE_BYPASS_EN
        push("byp_x9", 32'h55, 32'h55, 2'b00, 32'h200);
`else
        push("byp_x9", 32'h33, 32'h33, 2'b11, 32'h200);
`endif
        check_out();
        push("post_x9", 32'h55, 32'h55, 2'b00, 32'h0);
        @(posedge clk); #1; check_out();

        @(negedge clk);
        set_idle();
        bus.we = 2'b01; bus.rd_idx = {5'd0, 5'd9}; bus.wb_data = {32'h0, 32'h77};
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
        bus.rs_idx = {5'd9, 5'd9};
        #1;
`ifdef REGFILE_BYPASS_EN
        push("byp_iss_x9", 32'h77, 32'h77, 2'b11, 32'h0);
`else
        push("byp_iss_x9", 32'h55, 32'h55, 2'b00, 32'h0);
`endif
        check_out();
        push("post_iss_x9", 32'h77, 32'h77, 2'b11, 32'h200);
        @(posedge clk); #1; check_out();

        @(negedge clk);
        set_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
